// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Request, memory-bus and response signals of the load/store
//                unit. The unit itself uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int XLEN = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [4:0]        req_rd;
    logic              flush;

    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic [4:0]        resp_rd;
    logic              resp_misaligned;
    logic              resp_illegal;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_funct3, req_rd, flush,
        input  mem_ack, mem_rdata, resp_ready,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output resp_valid, resp_data, resp_rd, resp_misaligned, resp_illegal
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_funct3, req_rd, flush,
        output mem_ack, mem_rdata, resp_ready,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  resp_valid, resp_data, resp_rd, resp_misaligned, resp_illegal
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding RISC-V load/store unit with lane
//                replication, byte strobes, load extension and flush handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam int c_NB    = XLEN / 8;
    localparam int c_OFFW  = $clog2(c_NB);
    localparam bit c_IS64  = (XLEN == 64);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("load_store_unit: XLEN must be 32 or 64");
        end
    endgenerate

    logic [1:0]       r_state;
    logic             r_flushed;
    logic [c_OFFW-1:0] r_off;
    logic             r_we;
    logic [2:0]       r_funct3;

    logic             r_mem_req;
    logic             r_mem_we;
    logic [XLEN-1:0]  r_mem_addr;
    logic [XLEN-1:0]  r_mem_wdata;
    logic [c_NB-1:0]  r_mem_wstrb;

    logic             r_resp_valid;
    logic [XLEN-1:0]  r_resp_data;
    logic [4:0]       r_resp_rd;
    logic             r_resp_mis;
    logic             r_resp_ill;

    logic             w_req_ready;
    logic             w_accept;
    logic [c_OFFW-1:0] w_off;
    logic             w_legal;
    logic             w_misaligned;
    logic [XLEN-1:0]  w_store_data;
    logic [c_NB-1:0]  w_size_mask;
    logic [c_NB-1:0]  w_store_mask;
    logic [XLEN-1:0]  w_lane;
    logic [XLEN-1:0]  w_word_s;
    logic [XLEN-1:0]  w_word_u;
    logic [XLEN-1:0]  w_load;

    assign w_req_ready = (r_state == c_S_IDLE) && !bus.flush;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_off       = bus.req_addr[c_OFFW-1:0];

    // Legality depends on direction: unsigned and LWU forms exist only for loads
    always_comb begin
        w_legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b011:                 w_legal = c_IS64;
            3'b100, 3'b101:         w_legal = !bus.req_we;
            3'b110:                 w_legal = !bus.req_we && c_IS64;
            default:                w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_store_data = bus.req_wdata;
        w_size_mask  = {c_NB{1'b1}};
        w_misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'd0: begin
                w_store_data = {c_NB{bus.req_wdata[7:0]}};
                w_size_mask  = c_NB'(1);
                w_misaligned = 1'b0;
            end
            2'd1: begin
                w_store_data = {(XLEN/16){bus.req_wdata[15:0]}};
                w_size_mask  = c_NB'(3);
                w_misaligned = bus.req_addr[0];
            end
            2'd2: begin
                w_store_data = {(XLEN/32){bus.req_wdata[31:0]}};
                w_size_mask  = c_NB'(15);
                w_misaligned = |bus.req_addr[1:0];
            end
            default: begin
                w_store_data = bus.req_wdata;
                w_size_mask  = {c_NB{1'b1}};
                w_misaligned = |bus.req_addr[2:0];
            end
        endcase
    end

    assign w_store_mask = w_size_mask << w_off;

    // Addressed lane lands in the low bits before extension
    assign w_lane = bus.mem_rdata >> {r_off, 3'b000};

    generate
        if (c_IS64) begin : g_word64
            assign w_word_s = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
            assign w_word_u = {{(XLEN-32){1'b0}}, w_lane[31:0]};
        end else begin : g_word32
            assign w_word_s = w_lane;
            assign w_word_u = w_lane;
        end
    endgenerate

    always_comb begin
        w_load = w_lane;
        case (r_funct3)
            3'b000:  w_load = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load = w_word_s;
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_lane[7:0]};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            3'b110:  w_load = w_word_u;
            default: w_load = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_flushed    <= 1'b0;
            r_off        <= '0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_rd    <= 5'd0;
            r_resp_mis   <= 1'b0;
            r_resp_ill   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_flushed <= 1'b0;
                    if (w_accept) begin
                        r_off     <= w_off;
                        r_we      <= bus.req_we;
                        r_funct3  <= bus.req_funct3;
                        r_resp_rd <= bus.req_rd;
                        if (!w_legal || w_misaligned) begin
                            r_state      <= c_S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= '0;
                            r_resp_ill   <= !w_legal;
                            r_resp_mis   <= w_legal && w_misaligned;
                        end else begin
                            r_state     <= c_S_WAIT;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.req_we;
                            r_mem_addr  <= {bus.req_addr[XLEN-1:c_OFFW], {c_OFFW{1'b0}}};
                            r_mem_wdata <= bus.req_we ? w_store_data : '0;
                            r_mem_wstrb <= bus.req_we ? w_store_mask : '0;
                        end
                    end
                end
                c_S_WAIT: begin
                    if (bus.mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= '0;
                        // A flush seen at any point during the bus op swallows its result
                        if (r_flushed || bus.flush) begin
                            r_state   <= c_S_IDLE;
                            r_flushed <= 1'b0;
                        end else begin
                            r_state      <= c_S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= r_we ? '0 : w_load;
                            r_resp_ill   <= 1'b0;
                            r_resp_mis   <= 1'b0;
                        end
                    end else if (bus.flush) begin
                        r_flushed <= 1'b1;
                    end
                end
                c_S_RESP: begin
                    if (bus.flush || bus.resp_ready) begin
                        r_state      <= c_S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = w_req_ready;
    assign bus.mem_req         = r_mem_req;
    assign bus.mem_we          = r_mem_we;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_wstrb       = r_mem_wstrb;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_data       = r_resp_data;
    assign bus.resp_rd         = r_resp_rd;
    assign bus.resp_misaligned = r_resp_mis;
    assign bus.resp_illegal    = r_resp_ill;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Bench for load_store_unit: cycle-timed expectations from a
//                transaction-level model, directed cases and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    localparam int XLEN = 32;
    localparam int NB   = XLEN / 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(XLEN)) bus ();

    load_store_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Expected DUT outputs for the current cycle
    logic            e_all = 1'b0;
    logic            e_req_ready = 1'b1;
    logic            e_mem_req = 1'b0;
    logic            e_mem_we = 1'b0;
    logic [XLEN-1:0] e_mem_addr = '0;
    logic [XLEN-1:0] e_mem_wdata = '0;
    logic [NB-1:0]   e_mem_wstrb = '0;
    logic            e_resp_valid = 1'b0;
    logic [XLEN-1:0] e_resp_data = '0;
    logic [4:0]      e_resp_rd = '0;
    logic            e_resp_mis = 1'b0;
    logic            e_resp_ill = 1'b0;

    logic [XLEN-1:0] cap_addr, cap_wdata, cap_resp_data;
    logic [NB-1:0]   cap_wstrb;
    logic            cap_we, cap_mis, cap_ill;
    int              n_resp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_illegal(input bit we, input logic [2:0] f3);
        if (we) return !(f3 <= 3'd2 || (f3 == 3'd3 && XLEN == 64));
        return !(f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5 ||
                 (XLEN == 64 && (f3 == 3'd3 || f3 == 3'd6)));
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [XLEN-1:0] addr);
        int lo;
        lo = int'(addr[2:0]);
        return (lo % m_bytes(f3)) != 0;
    endfunction

    function automatic logic [XLEN-1:0] m_load(input logic [2:0] f3, input logic [XLEN-1:0] rdata, input int off);
        longint unsigned v, mask;
        int nb;
        nb   = m_bytes(f3);
        v    = 64'(rdata) >> (8 * off);
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v    = v & mask;
        if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | ~mask;
        return v[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] m_wdata(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = wd[8*(i % m_bytes(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [NB-1:0] m_wstrb(input logic [2:0] f3, input int off);
        logic [NB-1:0] r;
        for (int i = 0; i < NB; i++) r[i] = (i >= off) && (i < off + m_bytes(f3));
        return r;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(bus.req_ready), 64'(e_req_ready));
            chk("mem_req", 64'(bus.mem_req), 64'(e_mem_req));
            chk("resp_valid", 64'(bus.resp_valid), 64'(e_resp_valid));
            if (e_mem_req || e_all) begin
                chk("mem_we", 64'(bus.mem_we), 64'(e_mem_we));
                chk("mem_addr", 64'(bus.mem_addr), 64'(e_mem_addr));
                chk("mem_wstrb", 64'(bus.mem_wstrb), 64'(e_mem_wstrb));
                if (e_mem_we || e_all) chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_mem_wdata));
            end
            if (e_resp_valid || e_all) begin
                chk("resp_data", 64'(bus.resp_data), 64'(e_resp_data));
                chk("resp_rd", 64'(bus.resp_rd), 64'(e_resp_rd));
                chk("resp_misaligned", 64'(bus.resp_misaligned), 64'(e_resp_mis));
                chk("resp_illegal", 64'(bus.resp_illegal), 64'(e_resp_ill));
            end
            if (bus.mem_req && bus.mem_ack) begin
                cap_addr  = bus.mem_addr;
                cap_wdata = bus.mem_wdata;
                cap_wstrb = bus.mem_wstrb;
                cap_we    = bus.mem_we;
            end
            if (bus.resp_valid && bus.resp_ready) begin
                cap_resp_data = bus.resp_data;
                cap_mis       = bus.resp_misaligned;
                cap_ill       = bus.resp_illegal;
                n_resp++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic go_idle();
        e_mem_req       = 1'b0;
        e_resp_valid    = 1'b0;
        e_req_ready     = 1'b1;
        bus.flush       = 1'b0;
        bus.resp_ready  = 1'b0;
        bus.mem_ack     = 1'b0;
    endtask

    task automatic set_reset_expect();
        e_all = 1'b1; e_req_ready = 1'b1; e_mem_req = 1'b0; e_mem_we = 1'b0;
        e_mem_addr = '0; e_mem_wdata = '0; e_mem_wstrb = '0; e_resp_valid = 1'b0;
        e_resp_data = '0; e_resp_rd = '0; e_resp_mis = 1'b0; e_resp_ill = 1'b0;
    endtask

    task automatic scramble_req();
        bus.req_addr   = XLEN'($urandom);
        bus.req_wdata  = XLEN'($urandom);
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_rd     = 5'($urandom);
    endtask

    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [XLEN-1:0] addr,
                           input logic [XLEN-1:0] wdata, input logic [4:0] rd,
                           input logic [XLEN-1:0] rdata, input int ack_dly, input int rdy_dly,
                           input int flush_at, input bit pre_flush);
        bit ill, mis, flushed, done;
        int off, fa;
        if (pre_flush) begin
            bus.req_valid = 1'b1;
            scramble_req();
            bus.flush   = 1'b1;
            e_req_ready = 1'b0;
            tick();
            bus.flush   = 1'b0;
            e_req_ready = 1'b1;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        bus.mem_ack    = 1'($urandom);
        tick();
        bus.req_valid = 1'b0;
        scramble_req();
        bus.mem_ack = 1'b0;
        ill = m_illegal(we, f3);
        mis = !ill && m_misaligned(f3, addr);
        off = int'(addr[2:0]) % NB;
        e_req_ready = 1'b0;
        fa = flush_at;
        if (!ill && !mis) begin
            e_mem_req   = 1'b1;
            e_mem_we    = we;
            e_mem_addr  = addr - XLEN'(off);
            e_mem_wdata = m_wdata(f3, wdata);
            e_mem_wstrb = we ? m_wstrb(f3, off) : '0;
            flushed = 1'b0;
            for (int k = 0; k <= ack_dly; k++) begin
                bus.mem_ack   = (k == ack_dly);
                bus.mem_rdata = (k == ack_dly) ? rdata : XLEN'($urandom);
                bus.flush     = (k == flush_at);
                if (k == flush_at) flushed = 1'b1;
                tick();
            end
            bus.mem_ack = 1'b0;
            bus.flush   = 1'b0;
            e_mem_req   = 1'b0;
            if (flushed) begin
                go_idle();
                return;
            end
            e_resp_valid = 1'b1;
            e_resp_data  = we ? '0 : m_load(f3, rdata, off);
            e_resp_rd    = rd;
            e_resp_mis   = 1'b0;
            e_resp_ill   = 1'b0;
            fa = -1;
        end else begin
            e_mem_req    = 1'b0;
            e_resp_valid = 1'b1;
            e_resp_data  = '0;
            e_resp_rd    = rd;
            e_resp_ill   = ill;
            e_resp_mis   = mis;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            bus.resp_ready = (k == rdy_dly);
            bus.flush      = (k == fa);
            bus.mem_ack    = 1'($urandom);
            bus.mem_rdata  = XLEN'($urandom);
            done = (k == rdy_dly) || (k == fa);
            tick();
            if (done) break;
        end
        go_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nr;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_we = 1'b0;
        bus.req_funct3 = 3'b000; bus.req_rd = '0; bus.flush = 1'b0; bus.mem_ack = 1'b0;
        bus.mem_rdata = '0; bus.resp_ready = 1'b0;
        reset = 1'b1;
        tick();
        set_reset_expect();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        e_all = 1'b0;
        chk("ready_after_reset", 64'(bus.req_ready), 64'd1);

        // LB sign extension from the top byte lane
        run_txn(1'b0, 3'b000, 32'h1003, 32'h0, 5'd1, 32'h80FF_0000, 0, 0, -1, 1'b0);
        chk("lb_mem_addr", 64'(cap_addr), 64'h1000);
        chk("lb_resp_data", 64'(cap_resp_data), 64'hFFFF_FF80);
        run_txn(1'b0, 3'b101, 32'h2002, 32'h0, 5'd2, 32'hBEEF_1234, 0, 0, -1, 1'b0);
        chk("lhu_resp_data", 64'(cap_resp_data), 64'h0000_BEEF);
        run_txn(1'b1, 3'b000, 32'h3001, 32'h0000_00AB, 5'd3, 32'h1234_5678, 0, 0, -1, 1'b0);
        chk("sb_mem_we", 64'(cap_we), 64'd1);
        chk("sb_mem_wdata", 64'(cap_wdata), 64'hABAB_ABAB);
        chk("sb_mem_wstrb", 64'(cap_wstrb), 64'b0010);
        chk("sb_resp_data", 64'(cap_resp_data), 64'd0);
        run_txn(1'b0, 3'b010, 32'h4002, 32'h0, 5'd4, 32'h0, 0, 0, -1, 1'b0);
        chk("lw_misaligned", 64'(cap_mis), 64'd1);
        run_txn(1'b0, 3'b011, 32'h5000, 32'h0, 5'd5, 32'h0, 0, 0, -1, 1'b0);
        chk("ld32_illegal", 64'(cap_ill), 64'd1);
        run_txn(1'b0, 3'b010, 32'h6004, 32'h0, 5'd6, 32'hCAFE_F00D, 5, 3, -1, 1'b0);
        chk("lw_slow_data", 64'(cap_resp_data), 64'hCAFE_F00D);
        nr = n_resp;
        run_txn(1'b0, 3'b010, 32'h7000, 32'h0, 5'd7, 32'h1, 5, 0, 2, 1'b0);
        chk("flush_wait_noresp", 64'(n_resp), 64'(nr));
        run_txn(1'b0, 3'b001, 32'h7102, 32'h0, 5'd8, 32'h8001_0000, 0, 1, -1, 1'b1);
        chk("lh_after_idle_flush", 64'(cap_resp_data), 64'hFFFF_8001);

        // Reset in the middle of a bus op
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h8000; bus.req_rd = 5'd9;
        tick();
        bus.req_valid = 1'b0;
        e_req_ready = 1'b0; e_mem_req = 1'b1; e_mem_we = 1'b0;
        e_mem_addr = 32'h8000; e_mem_wstrb = '0;
        tick();
        reset = 1'b1;
        tick();
        set_reset_expect();
        reset = 1'b0;
        tick();
        e_all = 1'b0;
        chk("ready_after_midwait_reset", 64'(bus.req_ready), 64'd1);

        for (int n = 0; n < 250; n++) begin
            bit we;
            logic [2:0] f3;
            logic [XLEN-1:0] addr;
            we   = 1'($urandom);
            f3   = 3'($urandom);
            addr = XLEN'($urandom);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(XLEN'(m_bytes(f3)) - 1);
            run_txn(we, f3, addr, XLEN'($urandom), 5'($urandom), XLEN'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : -1,
                    $urandom_range(0, 7) == 0);
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
